// File: rtl/arm_check_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arm_check_pkg
// Brief   : Shared types for the writeback trace checker (state, entry).
// Revision: 1.0
// ============================================================================
package arm_check_pkg;

    localparam int WB_DEST_W = 4;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_t;

    typedef struct packed {
        logic [WB_DEST_W-1:0] dest;
        logic [WB_DATA_W-1:0] value;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_expect_mem.sv
`default_nettype none
// ============================================================================
// Module  : wb_expect_mem
// Brief   : Expected-writeback table, DEPTH x 36 bit, sync write, async read.
// Revision: 1.0
// ============================================================================
module wb_expect_mem
    import arm_check_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  wb_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output wb_entry_t     rdata
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    wb_entry_t r_mem [DEPTH];

    // No reset: the table must survive rst so a run can be repeated.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < c_depth)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < c_depth) ? r_mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/wb_trace_checker.sv
`default_nettype none
// ============================================================================
// Module  : wb_trace_checker
// Brief   : Compares observed register writebacks against a loaded table.
//           Optional macro WB_CHECK_SKIP_PC_EN ignores R15 writebacks.
// Revision: 1.0
// ============================================================================
module wb_trace_checker
    import arm_check_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     exp_we,
    input  logic [$clog2(DEPTH)-1:0] exp_addr,
    input  logic [WB_DEST_W-1:0]     exp_dest,
    input  logic [WB_DATA_W-1:0]     exp_value,
    input  logic [$clog2(DEPTH):0]   exp_count,
    input  logic                     wb_en,
    input  logic [WB_DEST_W-1:0]     wb_dest,
    input  logic [WB_DATA_W-1:0]     wb_value,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(DEPTH)-1:0] fail_index,
    output logic [31:0]              cycle_count,
    output logic [31:0]              wb_total
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_cnt_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);
    localparam logic [32:0] c_timeout  = 33'(TIMEOUT);

    chk_state_t    r_state;
    chk_state_t    w_state_next;
    logic [AW-1:0] r_pointer;
    logic [AW:0]   r_exp_count;
    logic [AW-1:0] r_fail_index;
    logic [31:0]   r_cycle_count;
    logic [31:0]   r_wb_total;

    wb_entry_t     w_wdata;
    wb_entry_t     w_rdata;
    logic          w_mem_we;
    logic          w_wb_valid;
    logic          w_hit;
    logic          w_last;
    logic          w_timeout;
    logic [AW:0]   w_count_clamped;

    assign w_wdata         = {exp_dest, exp_value};
    assign w_mem_we        = exp_we && (r_state == ST_IDLE);
    assign w_count_clamped = (exp_count > c_depth) ? c_depth : exp_count;

    wb_expect_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (exp_addr),
        .wdata (w_wdata),
        .raddr (r_pointer),
        .rdata (w_rdata)
    );

`ifdef WB_CHECK_SKIP_PC_EN
    assign w_wb_valid = wb_en && (wb_dest != 4'hF);
`else
    assign w_wb_valid = wb_en;
`endif

    assign w_hit     = (w_rdata.dest == wb_dest) && (w_rdata.value == wb_value);
    assign w_last    = (({1'b0, r_pointer} + c_cnt_one) == r_exp_count);
    // Fires on the edge that would bring cycle_count up to TIMEOUT.
    assign w_timeout = (({1'b0, r_cycle_count} + 33'd1) >= c_timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (w_count_clamped == '0) ? ST_PASS : ST_RUN;
                end
            end
            ST_RUN: begin
                // A writeback verdict outranks a coincident timeout.
                if (w_wb_valid && !w_hit) begin
                    w_state_next = ST_FAIL;
                end else if (w_wb_valid && w_last) begin
                    w_state_next = ST_PASS;
                end else if (w_timeout) begin
                    w_state_next = ST_FAIL;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pointer     <= '0;
            r_exp_count   <= '0;
            r_fail_index  <= '0;
            r_cycle_count <= '0;
            r_wb_total    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pointer     <= '0;
                        r_exp_count   <= w_count_clamped;
                        r_fail_index  <= '0;
                        r_cycle_count <= '0;
                        r_wb_total    <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_cycle_count != 32'hFFFF_FFFF) begin
                        r_cycle_count <= r_cycle_count + 32'd1;
                    end
                    if (w_wb_valid) begin
                        r_wb_total <= r_wb_total + 32'd1;
                        if (w_hit) begin
                            r_pointer <= r_pointer + c_ptr_one;
                        end
                    end
                    // A timeout right after a non-final match blames the next entry.
                    if (w_state_next == ST_FAIL) begin
                        r_fail_index <= (w_wb_valid && w_hit) ? (r_pointer + c_ptr_one)
                                                              : r_pointer;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done        = (r_state == ST_PASS) || (r_state == ST_FAIL);
    assign pass        = (r_state == ST_PASS);
    assign fail_index  = r_fail_index;
    assign cycle_count = r_cycle_count;
    assign wb_total    = r_wb_total;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_trace_checker
// Brief   : Directed table-driven bench for wb_trace_checker (DEPTH=16, TIMEOUT=20).
// Revision: 1.0
// ============================================================================
module tb_wb_trace_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_addr = '0;
    logic [3:0]  exp_dest = '0;
    logic [31:0] exp_value = '0;
    logic [4:0]  exp_count = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic        done;
    logic        pass;
    logic [3:0]  fail_index;
    logic [31:0] cycle_count;
    logic [31:0] wb_total;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_trace_checker #(
        .DEPTH   (16),
        .TIMEOUT (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .exp_we      (exp_we),
        .exp_addr    (exp_addr),
        .exp_dest    (exp_dest),
        .exp_value   (exp_value),
        .exp_count   (exp_count),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_value    (wb_value),
        .done        (done),
        .pass        (pass),
        .fail_index  (fail_index),
        .cycle_count (cycle_count),
        .wb_total    (wb_total)
    );

    typedef struct {
        string       name;
        logic [4:0]  cnt;
        logic        e_pass;
        logic [3:0]  e_fi;
        logic [31:0] e_cc;
        logic [31:0] e_wt;
    } vec_t;

    typedef struct {
        int          id;
        int          cyc;
        logic [3:0]  dst;
        logic [31:0] val;
    } wb_t;

    vec_t vecs[$];
    wb_t  wbs[$];

    task automatic addv(string n, int cnt, bit p, int fi, int cc, int wt);
        vec_t v;
        v.name   = n;
        v.cnt    = 5'(cnt);
        v.e_pass = p;
        v.e_fi   = 4'(fi);
        v.e_cc   = 32'(cc);
        v.e_wt   = 32'(wt);
        vecs.push_back(v);
    endtask

    task automatic addw(int cyc, int d, int val);
        wb_t w;
        w.id  = vecs.size() - 1;
        w.cyc = cyc;
        w.dst = 4'(d);
        w.val = 32'(val);
        wbs.push_back(w);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; wb_en = 1'b0; exp_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(int a, int d, int v);
        @(negedge clk);
        exp_we = 1'b1; exp_addr = 4'(a); exp_dest = 4'(d); exp_value = 32'(v);
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic load_table();
        load(0, 1, 5);
        load(1, 2, 7);
        load(2, 1, 12);
    endtask

    task automatic check_out(string nm, logic e_done, logic e_pass, logic [3:0] e_fi,
                             logic [31:0] e_cc, logic [31:0] e_wt);
        chk({nm, ".done"},        32'(done),        32'(e_done));
        chk({nm, ".pass"},        32'(pass),        32'(e_pass));
        chk({nm, ".fail_index"},  32'(fail_index),  32'(e_fi));
        chk({nm, ".cycle_count"}, cycle_count,      e_cc);
        chk({nm, ".wb_total"},    wb_total,         e_wt);
    endtask

    // Starts a run and drives the vector's writebacks; cycle n is the RUN cycle
    // during which cycle_count reads n.
    task automatic run_vec(int i, bit fresh);
        if (fresh) begin
            do_reset();
            load_table();
        end
        @(negedge clk);
        exp_count = vecs[i].cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            wb_en = 1'b0;
            foreach (wbs[k]) begin
                if (wbs[k].id == i && wbs[k].cyc == c) begin
                    wb_en = 1'b1; wb_dest = wbs[k].dst; wb_value = wbs[k].val;
                end
            end
            @(negedge clk);
        end
        wb_en = 1'b0;
        check_out(vecs[i].name, 1'b1, vecs[i].e_pass, vecs[i].e_fi, vecs[i].e_cc, vecs[i].e_wt);
    endtask

    initial begin
        // Table: entry0 R1=5, entry1 R2=7, entry2 R1=12.
        addv("pass_basic", 3, 1, 0, 7, 3);
        addw(2, 1, 5); addw(5, 2, 7); addw(6, 1, 12);
        addv("bad_second", 3, 0, 1, 6, 2);
        addw(2, 1, 5); addw(5, 2, 8); addw(6, 1, 12);
        addv("timeout", 3, 0, 2, 20, 2);
        addw(2, 1, 5); addw(5, 2, 7);
        addv("last_at_timeout", 3, 1, 0, 20, 3);
        addw(2, 1, 5); addw(5, 2, 7); addw(19, 1, 12);
`ifdef WB_CHECK_SKIP_PC_EN
        addv("r15_mix", 3, 1, 0, 7, 3);
`else
        addv("r15_mix", 3, 0, 0, 2, 1);
`endif
        addw(1, 15, 99); addw(2, 1, 5); addw(3, 15, 4); addw(5, 2, 7); addw(6, 1, 12);
        addv("empty", 0, 1, 0, 0, 0);
        addv("two_entries", 2, 1, 0, 2, 2);
        addw(0, 1, 5); addw(1, 2, 7);
        addv("bad_first_dest", 3, 0, 0, 1, 1);
        addw(0, 3, 5);
        addv("back_to_back", 3, 1, 0, 3, 3);
        addw(0, 1, 5); addw(1, 2, 7); addw(2, 1, 12);
        addv("clamp", 31, 0, 3, 20, 3);
        addw(0, 1, 5); addw(1, 2, 7); addw(2, 1, 12);

        do_reset();
        check_out("reset", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, 1'b1);
        end

        // Reset mid-run after one match, then a full run without reloading.
        do_reset();
        load_table();
        @(negedge clk);
        exp_count = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'd5;
        @(negedge clk);
        wb_en = 1'b0;
        @(negedge clk);
        chk("abort.pre_wb_total", wb_total, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_out("abort", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        run_vec(0, 1'b0);

        // In PASS: table writes, writebacks and start must all be ignored.
        @(negedge clk);
        exp_we = 1'b1; exp_addr = 4'd1; exp_dest = 4'd2; exp_value = 32'd8;
        start = 1'b1; wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'd5;
        @(negedge clk);
        @(negedge clk);
        exp_we = 1'b0; start = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        check_out("hold_pass", 1'b1, 1'b1, 4'd0, 32'd7, 32'd3);

        // Writebacks in IDLE are not counted; table still holds R2=7.
        do_reset();
        @(negedge clk);
        wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'd5;
        @(negedge clk);
        @(negedge clk);
        wb_en = 1'b0;
        check_out("idle_wb", 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        run_vec(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_trace_checker.md
WB_TRACE_CHECKER -- requirements
Module: wb_trace_checker

Interface
REQ-001 Parameter DEPTH, default 16: number of expected writeback entries held.
REQ-002 Parameter TIMEOUT, default 1000: cycles allowed in RUN before failing.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  pulse; leave IDLE and begin checking.
REQ-006 exp_we, exp_addr, exp_dest, exp_value  input  1/log2(DEPTH)/4/32  expected-table write port; usable only in IDLE.
REQ-007 exp_count  input  log2(DEPTH)+1  number of valid entries; sampled on start.
REQ-008 wb_en, wb_dest, wb_value  input  1/4/32  processor register-file writeback port under observation.
REQ-009 done, pass  output  1/1  verdict; pass is meaningful only when done=1.
REQ-010 fail_index  output  log2(DEPTH)  index of first mismatching entry.
REQ-011 cycle_count  output  32  cycles spent in RUN.
REQ-012 wb_total  output  32  writebacks observed in RUN.

Function
REQ-013 States: IDLE, RUN, PASS, FAIL; encoding from the shared package.
REQ-014 IDLE->RUN on start=1; pointer, cycle_count and wb_total clear in the same edge.
REQ-015 If exp_count=0, start goes IDLE->PASS directly.
REQ-016 In RUN, each wb_en=1 cycle compares {wb_dest,wb_value} against entry[pointer]; the verdict is registered one cycle later.
REQ-017 Match: pointer increments; on the match of entry exp_count-1, go to PASS.
REQ-018 Mismatch: go to FAIL; fail_index=pointer.
REQ-019 cycle_count increments every RUN cycle and saturates at 32'hFFFF_FFFF.
REQ-020 cycle_count reaching TIMEOUT with entries outstanding: go to FAIL; fail_index=pointer.
REQ-021 Timeout and a writeback in the same cycle: the compare result takes priority.
REQ-022 PASS and FAIL hold until rst; start is ignored there; done=1 in both; pass=1 only in PASS.
REQ-023 wb_en is ignored outside RUN; wb_total is frozen outside RUN.
REQ-024 exp_we outside IDLE is ignored; table contents persist across start.
REQ-025 exp_addr >= DEPTH: write is dropped.
REQ-026 start with exp_count > DEPTH: clamp exp_count to DEPTH.

Reset
REQ-027 rst=1: state IDLE, done=0, pass=0, fail_index=0, cycle_count=0, wb_total=0, pointer=0.
REQ-028 Reset mid-RUN aborts with no verdict; expected-table contents are not cleared.

Configuration
REQ-029 Macro WB_CHECK_SKIP_PC_EN.
- Defined: wb_en cycles with wb_dest=4'hF are ignored. They are not compared and not counted in wb_total.
- Undefined: R15 writebacks are compared like any other register.

Structure
REQ-030 Package arm_check_pkg holds:
- state enum
- WB_DEST_W=4
- WB_DATA_W=32
- the packed expected-entry type {dest, value}
REQ-031 The expected table is sub-module wb_expect_mem: DEPTH x 36-bit, one synchronous write port, one asynchronous read port.

Verification
REQ-032 Load 3 entries (R1=5, R2=7, R1=12), start, drive matching writebacks on cycles 2, 5, 6 -> PASS, pass=1, wb_total=3, cycle_count=7.
REQ-033 Same table, second writeback R2=8 -> FAIL, fail_index=1; cycle 6 writeback then ignored.
REQ-034 TIMEOUT=20, only 2 of 3 writebacks arrive -> FAIL at cycle_count=20, fail_index=2.
REQ-035 Last match lands in the same cycle as timeout -> PASS.
REQ-036 rst in RUN after 1 match, then start again -> fresh run from entry 0; table intact; PASS on full sequence.
REQ-037 With WB_CHECK_SKIP_PC_EN, interleave R15 writebacks -> PASS, and wb_total excludes them; without the macro -> FAIL at the first R15 writeback.
